// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//   Responder end of the CPU data-SRAM interface. Accepts one request per
//   cycle from the EX stage and returns data one cycle later. Reads return the
//   stored word. Writes update only the enabled byte lanes and return the
//   merged word (write-first). Also captures out-of-range accesses and counts
//   accepted reads and writes for debug.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-high reset (array contents survive)
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables, 0 = read
//   data_sram_addr   byte address (bits [1:0] ignored)
//   data_sram_wdata  lane-positioned write data
//   data_sram_rdata  registered read data, held while idle
//   cnt_clr          synchronous clear of both counters (beats increments)
//   err              sticky out-of-range flag
//   err_addr         address of the first out-of-range access
//   rd_cnt           accepted reads, wraps modulo 2^32
//   wr_cnt           accepted writes, wraps modulo 2^32
// -----------------------------------------------------------------------------
module data_sram_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        cnt_clr,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int AW = $clog2(DEPTH);

  // NOTE: the array has no reset. Clearing it would cost a full-array write
  // port sequence and would break "contents survive reset". The declaration
  // initialiser gives a defined zero image at time 0 in simulation only.
  logic [31:0] r_mem [DEPTH] = '{default: '0};

  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_err_addr;
  logic [31:0]   r_rd_cnt;
  logic [31:0]   r_wr_cnt;

  logic [31:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic          w_rd;
  logic          w_wr;
  logic          w_oob;
  logic          w_mem_we;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    w_off      = data_sram_addr - BASE_ADDR;   // modular; below-base wraps high
    w_in_range = (w_off[31:AW+2] == '0);
    w_idx      = w_off[AW+1:2];
    w_old      = r_mem[w_idx];
    w_merged   = w_old;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) w_merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
    // Every qualifier is ANDed with en so X on addr/wen/wdata while idle
    // cannot reach state.
    w_rd     = data_sram_en &  w_in_range & (data_sram_wen == 4'b0000);
    w_wr     = data_sram_en &  w_in_range & (data_sram_wen != 4'b0000);
    w_oob    = data_sram_en & ~w_in_range;
    // A write presented while reset is asserted must not land in the array.
    w_mem_we = w_wr & ~rst;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_merged;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      // rdata only moves on a request; the MEM stage relies on it holding.
      if (w_rd)       r_rdata <= w_old;
      else if (w_wr)  r_rdata <= w_merged;
      else if (w_oob) r_rdata <= '0;

      if (w_oob) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= data_sram_addr;
      end

      if (cnt_clr) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_rd) r_rd_cnt <= r_rd_cnt + 32'd1;
        if (w_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  assign data_sram_rdata = r_rdata;
  assign err             = r_err;
  assign err_addr        = r_err_addr;
  assign rd_cnt          = r_rd_cnt;
  assign wr_cnt          = r_wr_cnt;

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the CPU data-SRAM interface.
- Accepts the enable, byte-write-enable, address and write-data strobes issued by the EX stage.
- Returns read data with a fixed one-cycle latency, so the MEM stage can consume `data_sram_rdata` in the cycle after issue.
- Also provides range-error capture and read/write access counters for simulation and debug.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_sram_en  input  1  access request this cycle.
- data_sram_wen  input  4  byte write enables; bit i writes byte lane i (bits 8i+7:8i); 0 means read.
- data_sram_addr  input  32  byte address.
- data_sram_wdata  input  32  write data, already lane-positioned by the requester.
- data_sram_rdata  output  32  registered read data.
- cnt_clr  input  1  synchronous clear of both access counters.
- err  output  1  sticky: an out-of-range access has occurred.
- err_addr  output  32  address of the first out-of-range access.
- rd_cnt  output  32  number of accepted reads.
- wr_cnt  output  32  number of accepted writes.

Behaviour:
- Reset (async, rst=1):
  - data_sram_rdata=0, err=0, err_addr=0, rd_cnt=0, wr_cnt=0.
  - Array contents are not touched by reset. They are zero-initialised at time 0 for simulation and survive reset.
- Indexing:
  - off = data_sram_addr - BASE_ADDR (32-bit modular subtraction).
  - in_range = (off >> 2) < DEPTH.
  - idx = off[log2(DEPTH)+1:2].
  - addr[1:0] is ignored; lane selection comes solely from wen.
- Read (en=1, wen=0, in_range):
  - Next edge: rdata <= mem[idx]. Latency is exactly 1 cycle.
  - rd_cnt increments.
- Write (en=1, wen!=0, in_range):
  - Next edge: each enabled lane i of mem[idx] <= wdata lane i; other lanes are unchanged.
  - rdata <= merged word (write-first), i.e. enabled lanes from wdata, others from old mem[idx].
  - wr_cnt increments.
- Back-to-back accesses:
  - A read in cycle N+1 of the word written in cycle N returns the new data.
  - There are no stalls or wait states; a new request is accepted every cycle.
- Idle (en=0):
  - rdata holds its previous value. This is required because the MEM stage may stall with its input register frozen.
  - No array or counter change.
  - wen and wdata are ignored.
- Out of range (en=1, !in_range):
  - No array write.
  - rdata <= 32'h0.
  - err <= 1.
  - If err was 0, err_addr <= data_sram_addr; later errors do not overwrite it.
  - rd_cnt and wr_cnt do not increment.
  - err and err_addr clear only on rst.
- Counters:
  - 32-bit, wrap modulo 2^32.
  - cnt_clr=1 forces both to 0 on the next edge and takes priority over a same-cycle increment; that access is not counted.
- Simultaneous events:
  - rst asserted mid-access aborts the access. A write presented in the reset cycle must not modify the array.
  - Deasserting rst is synchronised externally; this block has no requirement on it.
- X-safety:
  - With en=0, X on addr, wen or wdata must not propagate to any output or state.

Test Plan:
1. Reset then read: assert rst, release; with en=1, wen=0, addr=BASE_ADDR+8 -> next cycle rdata=0, rd_cnt=1, err=0.
2. Byte-lane write merge:
   - Write 32'hAABBCCDD with wen=4'b1111 to addr 0x10.
   - Then write 32'h11223344 with wen=4'b0101 to the same address -> rdata after the second write = 32'hAA22CC44.
   - A following read returns 32'hAA22CC44; wr_cnt=2.
3. Write-then-read back-to-back: write 32'hDEADBEEF to 0x20 in cycle N, read 0x20 in cycle N+1 -> rdata in cycle N+2 = 32'hDEADBEEF; no bubble.
4. Hold on idle: read 0x20 (rdata=32'hDEADBEEF), then en=0 for 5 cycles with random addr, wen and wdata -> rdata stays 32'hDEADBEEF; counters unchanged; mem[0x20>>2] unchanged.
5. Out of range, DEPTH=1024, BASE_ADDR=0:
   - Write to 0x1000 -> no array change, rdata=0, err=1, err_addr=0x1000.
   - A later read of 0x2000 leaves err_addr=0x1000; wr_cnt and rd_cnt are unchanged by both.
6. Counter clear and reset priority:
   - cnt_clr=1 coincident with a read -> rd_cnt=0 next cycle.
   - Assert rst asynchronously mid-cycle during a write of 32'h12345678 to 0x30 -> outputs are 0 immediately, and a later read of 0x30 returns the prior contents.
